multi_alarm_clock_ctrl: RTL and testbench
=========================================

Name: multi_alarm_clock_ctrl

Overview:
Parametrised successor to the single-alarm clock top. It keeps a BCD 24-hour time of day and holds NUM_ALARMS independently enabled alarm registers. It runs a key-entry FSM for setting time or a selected alarm, plus snooze, stop and auto-timeout sequencing for the sounding alarm. It sits between the keypad/button front end and the 4-digit display driver.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8)
CYCLES_PER_MIN, 15360, clock cycles per minute tick (prescaler terminal count)
SNOOZE_MIN, 5, minutes before a snoozed alarm re-sounds (1..59)
ALARM_TIMEOUT_MIN, 10, minutes of unattended sounding before auto-stop (1..59)
KEY_TIMEOUT, 2560, idle cycles in key entry before the buffer is abandoned

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
key  in  4  BCD keypad digit 0-9; values 10-15 are ignored
key_valid  in  1  single-cycle strobe qualifying key
time_button  in  1  single-cycle strobe: commit buffer to time
alarm_button  in  1  single-cycle strobe: commit buffer to alarm[alarm_sel]
alarm_sel  in  AW=max(1,$clog2(NUM_ALARMS))  target alarm slot
alarm_enable  in  NUM_ALARMS  per-slot arm bits (level)
snooze  in  1  single-cycle strobe
stop_alarm  in  1  single-cycle strobe
ms_hour, ls_hour, ms_minute, ls_minute  out  4 each  displayed BCD digits
alarm_sound  out  1  alarm active
alarm_id  out  AW  slot currently sounding/snoozed
entry_busy  out  1  key-entry FSM not IDLE

Behaviour:
- Reset: time 00:00, all alarms 00:00, prescaler 0, FSM IDLE, buffer 0000; all outputs 0.
- Prescaler counts 0..CYCLES_PER_MIN-1. Terminal count produces a one-cycle min_tick. Time advances on min_tick with BCD carry: ls_min 9->0, ms_min 5->0, 23:59->00:00.
- Key FSM states: IDLE, ENTRY.
  - key_valid with key<=9: buffer shifts left one digit, new digit enters ls position, FSM -> ENTRY.
  - In ENTRY the display shows the buffer; otherwise it shows the time.
  - time_button in ENTRY: if buffer is a legal time (hh<=23, mm<=59), load time and zero the prescaler. Always -> IDLE with buffer cleared. Illegal buffer is discarded, no load.
  - alarm_button in ENTRY: same legality rule, loads alarm[alarm_sel]. alarm_sel>=NUM_ALARMS is discarded.
  - Buttons in IDLE are ignored.
  - KEY_TIMEOUT idle cycles in ENTRY -> IDLE, buffer cleared. Any key_valid restarts the idle count.
- Alarm FSM states: QUIET, SOUNDING, SNOOZED.
  - QUIET: on the cycle after a time update (min_tick or time load), any enabled slot equal to time -> SOUNDING. The lowest-index match is latched into alarm_id. A timeout counter is cleared on entry.
  - SOUNDING: alarm_sound=1. stop_alarm -> QUIET. snooze -> SNOOZED with a snooze counter of SNOOZE_MIN. ALARM_TIMEOUT_MIN min_ticks -> QUIET. Stop wins if stop and snooze are asserted in the same cycle.
  - SNOOZED: alarm_sound=0. The snooze counter decrements per min_tick; at 0 -> SOUNDING with timeout reset. stop_alarm -> QUIET. Clearing alarm_enable[alarm_id] -> QUIET.
- New matches are ignored while SOUNDING or SNOOZED.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- Display outputs are registered: one cycle of latency from time or buffer change.

Optional Feature:
DISPLAY_12H_EN.
- Defined: adds input mode_12h and output pm. When mode_12h=1, the hour is displayed as 12,1..12 with pm=1 for 12:00-23:59 (00:xx shows 12, pm=0). Entry and storage remain 24-hour.
- Undefined: 24-hour display only, and neither port exists.

Decomposition:
- Package macl_pkg holds: BCD digit typedef, time struct {mh, lh, mm, lm}, alarm FSM state enum, key FSM state enum, the legality-check function, and the BCD minute-increment function.
- One natural sub-module, bcd_time_counter: prescaler plus BCD minute/hour counter with a synchronous load.

Test Plan:
- Keys 2,3,5,9 + time_button, then one min_tick -> display 00:00 (23:59 rolls over); ms_hour=0, ls_minute=0.
- Keys 2,4,0,0 + time_button -> time unchanged, FSM IDLE, entry_busy=0.
- alarm[2]=07:30 and alarm[1]=07:30 both enabled, time reaches 07:30 -> alarm_sound=1 the cycle after the update, alarm_id=1.
- SOUNDING, snooze, then 5 min_ticks -> sound off for 5 minutes, back on at 07:35; stop and snooze in the same cycle -> QUIET.
- SOUNDING with no input for 10 min_ticks -> alarm_sound=0 at 07:40, state QUIET.
- Keys 1,2 then KEY_TIMEOUT idle cycles -> entry_busy=0, display shows time; a later time_button is ignored.

Source files
------------

// File: rtl/macl_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock controller.
package macl_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t mh;
        bcd_t lh;
        bcd_t mm;
        bcd_t lm;
    } clk_time_t;

    typedef enum logic [1:0] {
        AL_QUIET    = 2'd0,
        AL_SOUNDING = 2'd1,
        AL_SNOOZED  = 2'd2
    } alarm_state_t;

    typedef enum logic {
        KEY_IDLE  = 1'b0,
        KEY_ENTRY = 1'b1
    } key_state_t;

    function automatic logic is_legal_time(input clk_time_t t);
        logic hour_ok;
        logic min_ok;
        if (t.mh < 4'd2) begin
            hour_ok = (t.lh <= 4'd9);
        end else begin
            hour_ok = (t.mh == 4'd2) && (t.lh <= 4'd3);
        end
        min_ok = (t.mm <= 4'd5) && (t.lm <= 4'd9);
        return hour_ok && min_ok;
    endfunction

    // One-minute BCD advance with 23:59 -> 00:00 wrap.
    function automatic clk_time_t bcd_min_inc(input clk_time_t t);
        clk_time_t n;
        n = t;
        if (t.lm != 4'd9) begin
            n.lm = t.lm + 4'd1;
        end else begin
            n.lm = 4'd0;
            if (t.mm != 4'd5) begin
                n.mm = t.mm + 4'd1;
            end else begin
                n.mm = 4'd0;
                if ((t.mh == 4'd2) && (t.lh == 4'd3)) begin
                    n.mh = 4'd0;
                    n.lh = 4'd0;
                end else if (t.lh == 4'd9) begin
                    n.lh = 4'd0;
                    n.mh = t.mh + 4'd1;
                end else begin
                    n.lh = t.lh + 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_alarm_clock_ctrl_bcd_time_counter.sv
// Minute prescaler plus BCD time-of-day register with synchronous load.
module bcd_time_counter
    import macl_pkg::*;
#(
    parameter int CYCLES_PER_MIN = 15360
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_time,
    output logic [15:0] cur_time,
    output logic        min_tick,
    output logic        time_upd
);

    localparam int PW = (CYCLES_PER_MIN > 1) ? $clog2(CYCLES_PER_MIN) : 1;

    logic [PW-1:0] presc_r;
    clk_time_t     time_r;
    logic          upd_r;

    assign min_tick = (presc_r == PW'(CYCLES_PER_MIN - 1));
    assign cur_time = time_r;
    assign time_upd = upd_r;

    // Prescaler, time register and the one-cycle "time just changed" flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
            time_r  <= '0;
            upd_r   <= 1'b0;
        end else begin
            if (load) begin
                time_r  <= load_time;
                presc_r <= '0;
            end else if (min_tick) begin
                time_r  <= bcd_min_inc(time_r);
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            upd_r <= load | min_tick;
        end
    end

endmodule

// File: rtl/multi_alarm_clock_ctrl.sv
// Multi-alarm 24-hour clock: key entry, alarm storage, snooze/stop/timeout.
// Optional 12-hour display selected by defining DISPLAY_12H_EN.
module multi_alarm_clock_ctrl
    import macl_pkg::*;
#(
    parameter int NUM_ALARMS        = 4,
    parameter int CYCLES_PER_MIN    = 15360,
    parameter int SNOOZE_MIN        = 5,
    parameter int ALARM_TIMEOUT_MIN = 10,
    parameter int KEY_TIMEOUT       = 2560,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            key,
    input  logic                  key_valid,
    input  logic                  time_button,
    input  logic                  alarm_button,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_enable,
    input  logic                  snooze,
    input  logic                  stop_alarm,
    output logic [3:0]            ms_hour,
    output logic [3:0]            ls_hour,
    output logic [3:0]            ms_minute,
    output logic [3:0]            ls_minute,
    output logic                  alarm_sound,
    output logic [AW-1:0]         alarm_id,
    output logic                  entry_busy
`ifdef DISPLAY_12H_EN
    ,
    input  logic                  mode_12h,
    output logic                  pm
`endif
);

    localparam int IW = $clog2(KEY_TIMEOUT + 1);

    key_state_t   key_state_r;
    clk_time_t    buf_r;
    logic [IW-1:0] idle_cnt_r;
    logic         entry_busy_r;

    alarm_state_t al_state_r;
    logic [5:0]   tmo_r;
    logic [5:0]   snz_r;
    logic         alarm_sound_r;
    logic [AW-1:0] alarm_id_r;

    clk_time_t    alarm_r [NUM_ALARMS];
    clk_time_t    cur_time_s;
    clk_time_t    disp_r;
    logic         min_tick_s;
    logic         time_upd_s;
    logic         buf_legal_s;
    logic         time_load_s;
    logic         alarm_load_s;
    logic         match_hit_s;
    logic [AW-1:0] match_id_s;

    assign buf_legal_s  = is_legal_time(buf_r);
    assign time_load_s  = (key_state_r == KEY_ENTRY) && time_button && buf_legal_s;
    assign alarm_load_s = (key_state_r == KEY_ENTRY) && !time_button && alarm_button &&
                          buf_legal_s && (int'(alarm_sel) < NUM_ALARMS);

    bcd_time_counter #(
        .CYCLES_PER_MIN (CYCLES_PER_MIN)
    ) u_time (
        .clock     (clock),
        .reset     (reset),
        .load      (time_load_s),
        .load_time (buf_r),
        .cur_time  (cur_time_s),
        .min_tick  (min_tick_s),
        .time_upd  (time_upd_s)
    );

    // Key-entry FSM: digit buffer, idle timeout, button commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_state_r  <= KEY_IDLE;
            buf_r        <= '0;
            idle_cnt_r   <= '0;
            entry_busy_r <= 1'b0;
        end else begin
            case (key_state_r)
                KEY_IDLE: begin
                    if (key_valid && (key <= 4'd9)) begin
                        buf_r        <= {buf_r.lh, buf_r.mm, buf_r.lm, key};
                        idle_cnt_r   <= '0;
                        key_state_r  <= KEY_ENTRY;
                        entry_busy_r <= 1'b1;
                    end
                end
                KEY_ENTRY: begin
                    if (time_button || alarm_button) begin
                        buf_r        <= '0;
                        key_state_r  <= KEY_IDLE;
                        entry_busy_r <= 1'b0;
                    end else if (key_valid) begin
                        idle_cnt_r <= '0;
                        if (key <= 4'd9) begin
                            buf_r <= {buf_r.lh, buf_r.mm, buf_r.lm, key};
                        end
                    end else if (idle_cnt_r == IW'(KEY_TIMEOUT - 1)) begin
                        buf_r        <= '0;
                        key_state_r  <= KEY_IDLE;
                        entry_busy_r <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IW'(1);
                    end
                end
                default: begin
                    buf_r        <= '0;
                    key_state_r  <= KEY_IDLE;
                    entry_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Alarm slot storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_load_s && (int'(alarm_sel) == i)) begin
                    alarm_r[i] <= buf_r;
                end
            end
        end
    end

    // Lowest-index enabled slot equal to the current time.
    always_comb begin
        match_hit_s = 1'b0;
        match_id_s  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_enable[i] && (alarm_r[i] == cur_time_s)) begin
                match_hit_s = 1'b1;
                match_id_s  = AW'(i);
            end else begin
                match_hit_s = match_hit_s;
                match_id_s  = match_id_s;
            end
        end
    end

    // Alarm FSM: stop beats snooze, snooze beats the unattended timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            al_state_r    <= AL_QUIET;
            tmo_r         <= '0;
            snz_r         <= '0;
            alarm_sound_r <= 1'b0;
            alarm_id_r    <= '0;
        end else begin
            case (al_state_r)
                AL_QUIET: begin
                    if (time_upd_s && match_hit_s) begin
                        al_state_r    <= AL_SOUNDING;
                        alarm_id_r    <= match_id_s;
                        tmo_r         <= '0;
                        alarm_sound_r <= 1'b1;
                    end
                end
                AL_SOUNDING: begin
                    if (stop_alarm) begin
                        al_state_r    <= AL_QUIET;
                        alarm_sound_r <= 1'b0;
                    end else if (snooze) begin
                        al_state_r    <= AL_SNOOZED;
                        snz_r         <= 6'(SNOOZE_MIN);
                        alarm_sound_r <= 1'b0;
                    end else if (min_tick_s) begin
                        if (tmo_r == 6'(ALARM_TIMEOUT_MIN - 1)) begin
                            al_state_r    <= AL_QUIET;
                            alarm_sound_r <= 1'b0;
                        end else begin
                            tmo_r <= tmo_r + 6'd1;
                        end
                    end
                end
                AL_SNOOZED: begin
                    if (stop_alarm || !alarm_enable[alarm_id_r]) begin
                        al_state_r <= AL_QUIET;
                    end else if (min_tick_s) begin
                        if (snz_r == 6'd1) begin
                            al_state_r    <= AL_SOUNDING;
                            tmo_r         <= '0;
                            alarm_sound_r <= 1'b1;
                        end else begin
                            snz_r <= snz_r - 6'd1;
                        end
                    end
                end
                default: begin
                    al_state_r    <= AL_QUIET;
                    alarm_sound_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DISPLAY_12H_EN
    logic pm_r;

    // Returns {pm, ms digit, ls digit} of a 24-hour BCD hour shown on a 12-hour face.
    function automatic logic [8:0] hour_12h(input bcd_t mh, input bcd_t lh);
        logic [4:0] h;
        logic [4:0] h12;
        h = (5'(mh) * 5'd10) + 5'(lh);
        if (h == 5'd0) begin
            h12 = 5'd12;
        end else if (h > 5'd12) begin
            h12 = h - 5'd12;
        end else begin
            h12 = h;
        end
        if (h12 >= 5'd10) begin
            return {(h >= 5'd12), 4'd1, 4'(h12 - 5'd10)};
        end else begin
            return {(h >= 5'd12), 4'd0, 4'(h12)};
        end
    endfunction

    // Display register; entry always shows the raw 24-hour buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_r <= '0;
            pm_r   <= 1'b0;
        end else if (key_state_r == KEY_ENTRY) begin
            disp_r <= buf_r;
            pm_r   <= 1'b0;
        end else if (mode_12h) begin
            {pm_r, disp_r.mh, disp_r.lh} <= hour_12h(cur_time_s.mh, cur_time_s.lh);
            disp_r.mm <= cur_time_s.mm;
            disp_r.lm <= cur_time_s.lm;
        end else begin
            disp_r <= cur_time_s;
            pm_r   <= 1'b0;
        end
    end

    assign pm = pm_r;
`else
    // Display register: buffer during entry, time of day otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_r <= '0;
        end else if (key_state_r == KEY_ENTRY) begin
            disp_r <= buf_r;
        end else begin
            disp_r <= cur_time_s;
        end
    end
`endif

    assign ms_hour     = disp_r.mh;
    assign ls_hour     = disp_r.lh;
    assign ms_minute   = disp_r.mm;
    assign ls_minute   = disp_r.lm;
    assign alarm_sound = alarm_sound_r;
    assign alarm_id    = alarm_id_r;
    assign entry_busy  = entry_busy_r;

endmodule

// File: tb/tb_multi_alarm_clock_ctrl.sv
// Directed bench for multi_alarm_clock_ctrl with a minute-level reference model.
module tb_multi_alarm_clock_ctrl;

    localparam int NA  = 4;
    localparam int CPM = 16;
    localparam int SNZ = 5;
    localparam int ATO = 10;
    localparam int KT  = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    key;
    logic          key_valid;
    logic          time_button;
    logic          alarm_button;
    logic [1:0]    alarm_sel;
    logic [NA-1:0] alarm_enable;
    logic          snooze;
    logic          stop_alarm;
    logic [3:0]    ms_hour;
    logic [3:0]    ls_hour;
    logic [3:0]    ms_minute;
    logic [3:0]    ls_minute;
    logic          alarm_sound;
    logic [1:0]    alarm_id;
    logic          entry_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: time as minutes since midnight, buffer as a decimal number.
    int m_min, m_pre, m_buf, m_idle, m_ast, m_id, m_tmo, m_snz;
    bit m_entry, m_upd;
    int m_alarm [NA];
    bit m_valid = 1'b0;
    int e_disp, e_id;
    bit e_sound, e_busy;

    multi_alarm_clock_ctrl #(
        .NUM_ALARMS        (NA),
        .CYCLES_PER_MIN    (CPM),
        .SNOOZE_MIN        (SNZ),
        .ALARM_TIMEOUT_MIN (ATO),
        .KEY_TIMEOUT       (KT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key          (key),
        .key_valid    (key_valid),
        .time_button  (time_button),
        .alarm_button (alarm_button),
        .alarm_sel    (alarm_sel),
        .alarm_enable (alarm_enable),
        .snooze       (snooze),
        .stop_alarm   (stop_alarm),
        .ms_hour      (ms_hour),
        .ls_hour      (ls_hour),
        .ms_minute    (ms_minute),
        .ls_minute    (ls_minute),
        .alarm_sound  (alarm_sound),
        .alarm_id     (alarm_id),
        .entry_busy   (entry_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp_val();
        return int'(ms_hour) * 1000 + int'(ls_hour) * 100 + int'(ms_minute) * 10 + int'(ls_minute);
    endfunction

    task automatic model_step();
        int hh, mm, hit_id, new_min;
        bit tick, hit, load;
        if (!reset) begin
            m_min = 0; m_pre = 0; m_buf = 0; m_idle = 0; m_entry = 1'b0; m_upd = 1'b0;
            m_ast = 0; m_id = 0; m_tmo = 0; m_snz = 0;
            foreach (m_alarm[i]) m_alarm[i] = 0;
            e_disp = 0; e_sound = 1'b0; e_id = 0; e_busy = 1'b0;
            m_valid = 1'b1;
            return;
        end
        tick   = (m_pre == CPM - 1);
        e_disp = m_entry ? m_buf : (m_min / 60) * 100 + (m_min % 60);
        hit = 1'b0;
        hit_id = 0;
        for (int i = 0; i < NA; i++) begin
            if (!hit && alarm_enable[i] && (m_alarm[i] == m_min)) begin
                hit = 1'b1;
                hit_id = i;
            end
        end
        case (m_ast)
            0: if (m_upd && hit) begin m_ast = 1; m_id = hit_id; m_tmo = 0; end
            1: begin
                if (stop_alarm) m_ast = 0;
                else if (snooze) begin m_ast = 2; m_snz = SNZ; end
                else if (tick) begin
                    m_tmo++;
                    if (m_tmo == ATO) m_ast = 0;
                end
            end
            2: begin
                if (stop_alarm || !alarm_enable[m_id]) m_ast = 0;
                else if (tick) begin
                    m_snz--;
                    if (m_snz == 0) begin m_ast = 1; m_tmo = 0; end
                end
            end
            default: m_ast = 0;
        endcase
        hh = m_buf / 100;
        mm = m_buf % 100;
        load = 1'b0;
        new_min = 0;
        if (m_entry && time_button) begin
            if (hh <= 23 && mm <= 59) begin load = 1'b1; new_min = hh * 60 + mm; end
            m_entry = 1'b0; m_buf = 0;
        end else if (m_entry && alarm_button) begin
            if (hh <= 23 && mm <= 59 && int'(alarm_sel) < NA) m_alarm[alarm_sel] = hh * 60 + mm;
            m_entry = 1'b0; m_buf = 0;
        end else if (key_valid) begin
            m_idle = 0;
            if (key <= 4'd9) begin m_buf = (m_buf % 1000) * 10 + int'(key); m_entry = 1'b1; end
        end else if (m_entry) begin
            m_idle++;
            if (m_idle >= KT) begin m_entry = 1'b0; m_buf = 0; end
        end
        if (load) begin m_min = new_min; m_pre = 0; end
        else if (tick) begin m_min = (m_min + 1) % 1440; m_pre = 0; end
        else m_pre++;
        m_upd   = load || tick;
        e_sound = (m_ast == 1);
        e_id    = m_id;
        e_busy  = m_entry;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                chk("display", disp_val(), e_disp);
                chk("alarm_sound", alarm_sound, e_sound);
                chk("alarm_id", alarm_id, e_id);
                chk("entry_busy", entry_busy, e_busy);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_key(input int k);
        key = 4'(k);
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press_key(a); press_key(b); press_key(c); press_key(d);
    endtask

    task automatic press_time();
        time_button = 1'b1;
        step(1);
        time_button = 1'b0;
    endtask

    task automatic press_alarm(input int sel);
        alarm_sel = 2'(sel);
        alarm_button = 1'b1;
        step(1);
        alarm_button = 1'b0;
    endtask

    initial begin
        reset = 1'b0; key = 4'd0; key_valid = 1'b0; time_button = 1'b0; alarm_button = 1'b0;
        alarm_sel = 2'd0; alarm_enable = '0; snooze = 1'b0; stop_alarm = 1'b0;
        step(3);
        chk("reset_display", disp_val(), 0);
        chk("reset_sound", alarm_sound, 0);
        chk("reset_busy", entry_busy, 0);
        reset = 1'b1;
        step(1);

        // 23:59 loads, then rolls over to 00:00 on the next minute tick.
        enter4(2, 3, 5, 9);
        press_time();
        chk("load_busy", entry_busy, 0);
        step(2);
        chk("load_2359", disp_val(), 2359);
        step(16);
        chk("rollover_0000", disp_val(), 0);

        // Illegal 24:00 is discarded; an out-of-range key is ignored.
        enter4(2, 4, 0, 0);
        press_time();
        step(1);
        chk("illegal_busy", entry_busy, 0);
        chk("illegal_display", disp_val(), 0);
        press_key(12);
        chk("badkey_busy", entry_busy, 0);

        // Alarms: slot0 07:31, slots 1 and 2 at 07:30.
        enter4(0, 7, 3, 1); press_alarm(0);
        enter4(0, 7, 3, 0); press_alarm(2);
        enter4(0, 7, 3, 0); press_alarm(1);
        alarm_enable = 4'b0111;
        enter4(0, 7, 2, 9);
        press_time();
        step(15);
        chk("pre_alarm_sound", alarm_sound, 0);
        step(1);
        chk("update_cycle_sound", alarm_sound, 0);
        step(1);
        chk("alarm_sound_on", alarm_sound, 1);
        chk("alarm_id_lowest", alarm_id, 1);

        // Snooze for five minutes, re-sound at 07:35.
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        chk("snoozed_sound", alarm_sound, 0);
        step(77);
        chk("still_snoozed", alarm_sound, 0);
        step(1);
        chk("resound", alarm_sound, 1);
        step(1);
        chk("resound_time", disp_val(), 735);

        // Stop and snooze together: stop wins.
        stop_alarm = 1'b1; snooze = 1'b1;
        step(1);
        stop_alarm = 1'b0; snooze = 1'b0;
        chk("stop_wins", alarm_sound, 0);
        step(100);
        chk("stays_quiet", alarm_sound, 0);

        // Unattended timeout after ten minutes.
        enter4(0, 7, 2, 9);
        press_time();
        step(17);
        chk("timeout_start", alarm_sound, 1);
        step(158);
        chk("timeout_before", alarm_sound, 1);
        step(1);
        chk("timeout_off", alarm_sound, 0);
        step(1);
        chk("timeout_time", disp_val(), 740);

        // Disarming the snoozed slot returns to quiet; slot0 can then match.
        enter4(0, 7, 2, 9);
        press_time();
        step(17);
        chk("disarm_start", alarm_sound, 1);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        alarm_enable = 4'b0001;
        step(15);
        chk("slot0_sound", alarm_sound, 1);
        chk("slot0_id", alarm_id, 0);
        stop_alarm = 1'b1;
        step(1);
        stop_alarm = 1'b0;
        chk("slot0_stopped", alarm_sound, 0);

        // Key-entry idle timeout; a later time button is ignored.
        press_key(1);
        press_key(2);
        chk("entry_busy_on", entry_busy, 1);
        step(KT - 1);
        chk("entry_before_timeout", entry_busy, 1);
        step(1);
        chk("entry_timed_out", entry_busy, 0);
        press_time();
        step(2);
        chk("ignored_button_busy", entry_busy, 0);

        // Asynchronous reset mid-operation.
        reset = 1'b0;
        #2;
        chk("async_reset_display", disp_val(), 0);
        chk("async_reset_busy", entry_busy, 0);
        step(2);
        reset = 1'b1;
        step(3);
        chk("after_reset_display", disp_val(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
